// File: rtl/trace_buffer.sv
// trace_buffer: armed instruction trace capture with pc trigger, post-trigger window and readout.
// Optional simulation display of each capture when TRACE_DISPLAY_EN is defined.
package constants_pkg;
    typedef enum logic [2:0] {
        FETCH_START,
        FETCH_END,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK
    } ExecutionStage;
endpackage

module trace_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int POST_W = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  constants_pkg::ExecutionStage    state,
    input  logic [ADDR_W-1:0]               pc,
    input  logic                            reg_we,
    input  logic [2:0]                      reg_waddr,
    input  logic [DATA_W-1:0]               reg_wdata,
    input  logic                            arm,
    input  logic                            trig_en,
    input  logic [ADDR_W-1:0]               trig_pc,
    input  logic [POST_W-1:0]               post_count,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [ADDR_W+DATA_W+3:0]        rd_data,
    output logic [1:0]                      mode,
    output logic [POST_W-1:0]               count,
    output logic                            wrapped
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W + 4;

    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} mode_t;

    mode_t              mode_q, mode_d;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
    logic [POST_W-1:0]  count_d, remaining, remaining_d;
    logic               wrapped_d;
    logic [DATA_W+3:0]  trk, trk_d;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   entry;
    logic               capture, trigger, pop, full;

    // a write on the capture cycle takes precedence over the latched tracker
    assign entry   = {pc, reg_we ? {1'b1, reg_waddr, reg_wdata} : trk};
    assign capture = !arm && (mode_q == ARMED || mode_q == POST) && state == constants_pkg::FETCH_END;
    assign trigger = capture && mode_q == ARMED && trig_en && pc == trig_pc;
    assign pop     = !arm && rd_valid && rd_ready;
    assign full    = count == POST_W'(DEPTH);

    always_comb begin
        mode_d      = mode_q;
        count_d     = count;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        wrapped_d   = wrapped;
        trk_d       = trk;
        remaining_d = remaining;
        if (arm) begin
            mode_d      = ARMED;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            wrapped_d   = 1'b0;
            trk_d       = '0;
            remaining_d = '0;
        end else begin
            if (reg_we)
                trk_d = {1'b1, reg_waddr, reg_wdata};
            if (capture) begin
                trk_d    = '0;
                wr_ptr_d = wr_ptr + 1'b1;
                if (full) begin
                    rd_ptr_d  = rd_ptr + 1'b1;
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            if (trigger) begin
                mode_d      = post_count == '0 ? FROZEN : POST;
                remaining_d = post_count;
            end
            if (capture && mode_q == POST) begin
                remaining_d = remaining - 1'b1;
                mode_d      = remaining == POST_W'(1) ? FROZEN : POST;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr + 1'b1;
                count_d  = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wrapped   <= 1'b0;
            trk       <= '0;
            remaining <= '0;
        end else begin
            mode_q    <= mode_d;
            count     <= count_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            wrapped   <= wrapped_d;
            trk       <= trk_d;
            remaining <= remaining_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            mem[wr_ptr] <= entry;
    end

    assign mode     = mode_q;
    assign rd_valid = mode_q == FROZEN && count != '0;
    assign rd_data  = count != '0 ? mem[rd_ptr] : '0;

`ifdef TRACE_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (capture)
            $display("trace pc=%h waddr=%0d wdata=%h mode=%0d", pc, entry[DATA_W+2:DATA_W], entry[DATA_W-1:0], mode_q);
        if (reset_n && mode_d == FROZEN && mode_q != FROZEN)
            $display("FROZEN count=%0d", count_d);
    end
`else
`endif
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_trace_buffer;
    import constants_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;
    localparam int POST_W = 5;
    localparam int ENT_W  = ADDR_W + DATA_W + 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    ExecutionStage       state = DECODE;
    logic [ADDR_W-1:0]   pc = '0;
    logic                reg_we = 1'b0;
    logic [2:0]          reg_waddr = '0;
    logic [DATA_W-1:0]   reg_wdata = '0;
    logic                arm = 1'b0;
    logic                trig_en = 1'b0;
    logic [ADDR_W-1:0]   trig_pc = '0;
    logic [POST_W-1:0]   post_count = '0;
    logic                rd_valid;
    logic                rd_ready = 1'b0;
    logic [ENT_W-1:0]    rd_data;
    logic [1:0]          mode;
    logic [POST_W-1:0]   count;
    logic                wrapped;

    int vectors = 0;
    int miscompares = 0;

    trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .POST_W(POST_W)) dut (
        .clk(clk), .reset_n(reset_n), .state(state), .pc(pc), .reg_we(reg_we),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .post_count(post_count), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .mode(mode), .count(count), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    // reference model: oldest entry at the front of the queue
    logic [ENT_W-1:0] mq[$];
    int               m_mode;
    logic             m_wrapped;
    logic [11:0]      m_trk;
    int               m_rem;

    function automatic void model_reset();
        mq.delete();
        m_mode = 0;
        m_wrapped = 1'b0;
        m_trk = '0;
        m_rem = 0;
    endfunction

    function automatic void model_clock();
        logic [ENT_W-1:0] e;
        if (arm) begin
            mq.delete();
            m_mode = 1;
            m_wrapped = 1'b0;
            m_trk = '0;
            return;
        end
        if ((m_mode == 1 || m_mode == 2) && state == FETCH_END) begin
            e = {pc, reg_we ? {1'b1, reg_waddr, reg_wdata} : m_trk};
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                m_wrapped = 1'b1;
            end
            mq.push_back(e);
            m_trk = '0;
            if (m_mode == 1 && trig_en && pc == trig_pc) begin
                if (post_count == 0) m_mode = 3;
                else begin
                    m_mode = 2;
                    m_rem = int'(post_count);
                end
            end else if (m_mode == 2) begin
                m_rem--;
                if (m_rem == 0) m_mode = 3;
            end
        end else begin
            if (reg_we) m_trk = {1'b1, reg_waddr, reg_wdata};
            if (m_mode == 3 && mq.size() > 0 && rd_ready) void'(mq.pop_front());
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_clock();
        @(negedge clk);
    endtask

    task automatic capture_at(input logic [ADDR_W-1:0] p);
        state = FETCH_END;
        pc = p;
        cyc();
        state = DECODE;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        reset_n = 1'b1;
        @(negedge clk);
        capture_at(8'd10);
        vectors++; if (count !== '0 || mode !== 2'd0) begin miscompares++; $display("FAIL idle_no_capture count=%0d mode=%0d exp 0/0", count, mode); end
    endtask

    task automatic test_no_trigger();
        trig_en = 1'b0;
        do_arm();
        vectors++; if (mode !== 2'd1 || count !== '0) begin miscompares++; $display("FAIL arm_state mode=%0d count=%0d exp 1/0", mode, count); end
        capture_at(8'd10);
        vectors++; if (count !== 5'd1 || rd_data[19:12] !== 8'd10) begin miscompares++; $display("FAIL first_capture count=%0d pc=%h exp 1/0a", count, rd_data[19:12]); end
        capture_at(8'd11);
        capture_at(8'd12);
        vectors++; if (count !== 5'd3 || mode !== 2'd1 || wrapped !== 1'b0) begin miscompares++; $display("FAIL three_captures count=%0d mode=%0d wrapped=%b exp 3/1/0", count, mode, wrapped); end
    endtask

    task automatic test_wrap();
        trig_en = 1'b1;
        trig_pc = 8'd19;
        post_count = '0;
        do_arm();
        for (int i = 0; i < 19; i++) capture_at(8'(i));
        vectors++; if (count !== 5'd16 || wrapped !== 1'b1 || mode !== 2'd1) begin miscompares++; $display("FAIL wrap_fill count=%0d wrapped=%b mode=%0d exp 16/1/1", count, wrapped, mode); end
        capture_at(8'd19);
        vectors++; if (mode !== 2'd3 || count !== 5'd16 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_freeze mode=%0d count=%0d rd_valid=%b exp 3/16/1", mode, count, rd_valid); end
        vectors++; if (rd_data[19:12] !== 8'd4) begin miscompares++; $display("FAIL wrap_oldest pc=%0d exp=4", rd_data[19:12]); end
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        vectors++; if (rd_data[19:12] !== 8'd5 || count !== 5'd15) begin miscompares++; $display("FAIL wrap_pop pc=%0d count=%0d exp 5/15", rd_data[19:12], count); end
    endtask

    task automatic test_post_trigger();
        trig_en = 1'b1;
        trig_pc = 8'h05;
        post_count = 5'd2;
        do_arm();
        for (int p = 3; p <= 9; p++) begin
            capture_at(8'(p));
            if (p == 6) begin
                vectors++; if (mode !== 2'd2) begin miscompares++; $display("FAIL post_mode got=%0d exp=2", mode); end
            end
            if (p == 7) begin
                vectors++; if (mode !== 2'd3) begin miscompares++; $display("FAIL post_freeze got=%0d exp=3", mode); end
            end
        end
        vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL post_count got=%0d exp=5", count); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (rd_valid !== 1'b1 || rd_data[19:12] !== 8'(3 + i)) begin miscompares++; $display("FAIL post_read%0d valid=%b pc=%0d exp 1/%0d", i, rd_valid, rd_data[19:12], 3 + i); end
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
        end
        vectors++; if (rd_valid !== 1'b0 || count !== '0) begin miscompares++; $display("FAIL post_drained valid=%b count=%0d exp 0/0", rd_valid, count); end
    endtask

    task automatic test_tracker();
        trig_en = 1'b1;
        trig_pc = 8'h21;
        post_count = '0;
        do_arm();
        reg_we = 1'b1; reg_waddr = 3'd2; reg_wdata = 8'hAB;
        cyc();
        reg_waddr = 3'd5; reg_wdata = 8'h3C;
        cyc();
        reg_we = 1'b0;
        capture_at(8'h20);
        vectors++; if (rd_data !== {8'h20, 1'b1, 3'd5, 8'h3C}) begin miscompares++; $display("FAIL tracker_entry got=%h exp=%h", rd_data, {8'h20, 1'b1, 3'd5, 8'h3C}); end
        capture_at(8'h21);
        vectors++; if (mode !== 2'd3 || count !== 5'd2) begin miscompares++; $display("FAIL tracker_freeze mode=%0d count=%0d exp 3/2", mode, count); end
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        vectors++; if (rd_data !== {8'h21, 12'h000}) begin miscompares++; $display("FAIL tracker_cleared got=%h exp=%h", rd_data, {8'h21, 12'h000}); end
    endtask

    task automatic test_readout();
        trig_en = 1'b1;
        trig_pc = 8'd1;
        post_count = 5'd1;
        do_arm();
        capture_at(8'd1);
        capture_at(8'd2);
        vectors++; if (mode !== 2'd3 || count !== 5'd2) begin miscompares++; $display("FAIL rd_frozen mode=%0d count=%0d exp 3/2", mode, count); end
        rd_ready = 1'b1;
        cyc();
        vectors++; if (count !== 5'd1 || rd_valid !== 1'b1 || rd_data[19:12] !== 8'd2) begin miscompares++; $display("FAIL rd_pop1 count=%0d valid=%b pc=%0d exp 1/1/2", count, rd_valid, rd_data[19:12]); end
        cyc();
        vectors++; if (count !== '0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_pop2 count=%0d valid=%b exp 0/0", count, rd_valid); end
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        rd_ready = 1'b0;
        vectors++; if (count !== '0 || mode !== 2'd1) begin miscompares++; $display("FAIL rd_rearm count=%0d mode=%0d exp 0/1", count, mode); end
        post_count = 5'd2;
        capture_at(8'd1);
        capture_at(8'd1);
        capture_at(8'd1);
        vectors++; if (mode !== 2'd3 || count !== 5'd3) begin miscompares++; $display("FAIL no_retrigger mode=%0d count=%0d exp 3/3", mode, count); end
        arm = 1'b1;
        rd_ready = 1'b1;
        cyc();
        arm = 1'b0;
        rd_ready = 1'b0;
        vectors++; if (count !== '0 || mode !== 2'd1 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL arm_over_pop count=%0d mode=%0d valid=%b exp 0/1/0", count, mode, rd_valid); end
    endtask

    task automatic test_reset_mid_post();
        trig_en = 1'b1;
        trig_pc = 8'd3;
        post_count = 5'd4;
        do_arm();
        capture_at(8'd3);
        capture_at(8'd4);
        vectors++; if (mode !== 2'd2 || count !== 5'd2) begin miscompares++; $display("FAIL midpost_setup mode=%0d count=%0d exp 2/2", mode, count); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (mode !== 2'd0 || count !== '0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset mode=%0d count=%0d valid=%b exp 0/0/0", mode, count, rd_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        capture_at(8'd5);
        capture_at(8'd3);
        vectors++; if (mode !== 2'd0 || count !== '0) begin miscompares++; $display("FAIL post_reset_ignore mode=%0d count=%0d exp 0/0", mode, count); end
        do_arm();
        capture_at(8'd6);
        vectors++; if (mode !== 2'd1 || count !== 5'd1) begin miscompares++; $display("FAIL post_reset_arm mode=%0d count=%0d exp 1/1", mode, count); end
    endtask

    task automatic test_random();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                vectors++; if (mode !== 2'd0 || count !== '0) begin miscompares++; $display("FAIL rand_reset mode=%0d count=%0d exp 0/0", mode, count); end
                @(negedge clk);
                reset_n = 1'b1;
            end
            arm        = $urandom_range(0, 39) == 0;
            state      = $urandom_range(0, 1) == 1 ? FETCH_END : ExecutionStage'($urandom_range(2, 5));
            pc         = 8'($urandom_range(0, 23));
            trig_en    = $urandom_range(0, 3) != 0;
            trig_pc    = 8'($urandom_range(0, 23));
            post_count = 5'($urandom_range(0, 5));
            rd_ready   = $urandom_range(0, 1) == 1;
            reg_we     = $urandom_range(0, 2) == 0;
            reg_waddr  = 3'($urandom);
            reg_wdata  = 8'($urandom);
            cyc();
            vectors++; if (mode !== 2'(m_mode)) begin miscompares++; $display("FAIL rand_mode cyc=%0d got=%0d exp=%0d", n, mode, m_mode); end
            vectors++; if (count !== 5'(mq.size())) begin miscompares++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, count, mq.size()); end
            vectors++; if (wrapped !== m_wrapped) begin miscompares++; $display("FAIL rand_wrapped cyc=%0d got=%b exp=%b", n, wrapped, m_wrapped); end
            vectors++; if (rd_valid !== (m_mode == 3 && mq.size() != 0)) begin miscompares++; $display("FAIL rand_rd_valid cyc=%0d got=%b", n, rd_valid); end
            if (mq.size() != 0) begin
                vectors++; if (rd_data !== mq[0]) begin miscompares++; $display("FAIL rand_rd_data cyc=%0d got=%h exp=%h", n, rd_data, mq[0]); end
            end
        end
        arm = 1'b0;
        state = DECODE;
        reg_we = 1'b0;
        rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_trigger();
        test_wrap();
        test_post_trigger();
        test_tracker();
        test_readout();
        test_reset_mid_post();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DATA_W, default 8: register data width.
REQ-002 Parameter ADDR_W, default 8: program counter width.
REQ-003 Parameter DEPTH, default 16: entry count; power of two, >= 2.
REQ-004 Parameter POST_W, default $clog2(DEPTH)+1: post-trigger count width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 state  in  constants_pkg::ExecutionStage  processor stage; capture strobe = (state == FETCH_END).
REQ-008 pc  in  ADDR_W  program counter sampled at capture.
REQ-009 reg_we / reg_waddr / reg_wdata  in  1 / 3 / DATA_W  register-file write port.
REQ-010 arm  in  1  single-cycle pulse; clears buffer and starts capture.
REQ-011 trig_en / trig_pc  in  1 / ADDR_W  trigger enable and match address.
REQ-012 post_count  in  POST_W  entries captured after the trigger entry; sampled at trigger.
REQ-013 rd_valid / rd_ready  out / in  1 / 1  readout handshake; pop when both high.
REQ-014 rd_data  out  ADDR_W+4+DATA_W  oldest entry {pc, wr_seen, waddr, wdata}.
REQ-015 mode  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3.
REQ-016 count  out  POST_W  valid entries held; wrapped  out  1  sticky overwrite flag.

Function
REQ-017 Write tracker: reg_we high latches {1, reg_waddr, reg_wdata}; the latest write since the previous capture wins; cleared by each capture.
REQ-018 Capture occurs in ARMED or POST when the capture strobe is high: entry = {pc, tracker}; a write on the same cycle is included.
REQ-019 Entry visible in count and rd_data one cycle after the capture edge.
REQ-020 Storage circular: wr_ptr and rd_ptr wrap modulo DEPTH.
REQ-021 Capture with count == DEPTH overwrites the oldest entry, advances rd_ptr, holds count at DEPTH and sets wrapped.
REQ-022 IDLE: no capture; arm -> ARMED.
REQ-023 ARMED: capture with trig_en and pc == trig_pc stores the trigger entry, then -> POST with remaining = post_count, or -> FROZEN if post_count == 0.
REQ-024 POST: each capture decrements remaining; the capture with remaining == 1 -> FROZEN.
REQ-025 FROZEN: no capture; rd_valid = (count != 0); a pop advances rd_ptr and decrements count; arm -> ARMED.
REQ-026 rd_valid is 0 outside FROZEN; rd_ready is ignored outside FROZEN.
REQ-027 arm in any mode clears count, pointers, wrapped and tracker -> ARMED next cycle; it overrides a capture, trigger or pop on the same cycle.
REQ-028 Trigger match when trig_en is low or mode is POST has no effect.
REQ-029 Pop and arm on the same cycle: arm wins; no entry is popped.

Reset
REQ-030 reset_n low asynchronously forces mode=IDLE, count=0, wrapped=0, rd_valid=0, rd_data=0, pointers=0, tracker=0.
REQ-031 Reset mid-POST or mid-readout discards all entries; storage array contents need no reset.
REQ-032 Capture resumes only after reset_n deassertion followed by arm.

Configuration
REQ-033 Macro TRACE_DISPLAY_EN defined: simulation-only $display of pc, waddr, wdata, mode at each capture and "FROZEN count=<n>" on entry to FROZEN.
REQ-034 Macro TRACE_DISPLAY_EN undefined: no display code elaborated; RTL behaviour identical in both cases.

Verification
REQ-035 Arm, 3 captures at pc 10,11,12 with no writes, trig_en=0 -> count=3, mode=ARMED, wrapped=0.
REQ-036 Arm, 20 captures pc 0..19 (DEPTH=16) -> count=16, wrapped=1; after trigger and freeze, first pop gives pc=4.
REQ-037 trig_pc=0x05, post_count=2, captures pc 3..9 -> FROZEN after pc 7; count=5 entries pc 3..7 in order; pc 8,9 not stored.
REQ-038 reg write r2=0xAB then r5=0x3C before capture at pc=0x20 -> entry {0x20,1,5,0x3C}; next capture without writes has wr_seen=0.
REQ-039 FROZEN with count=2, rd_ready held high -> two pops over two cycles, then rd_valid=0; arm with rd_ready high -> count=0, mode=ARMED.
REQ-040 reset_n pulsed low mid-POST -> mode=IDLE, count=0 immediately; captures ignored until arm.
